// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle on operand magnitudes, then a sign fix-up.
module muldiv_hilo_unit #(
    parameter int WIDTH           = 32,
    parameter bit ZERO_DIV_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    // Handshake: start/mthi/mtlo are accepted only while busy is low; done is a
    // one-cycle pulse after busy falls, and hi/lo already hold the result then.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    step;
    logic             op_div, sign_a, sign_b, div_zero;
    logic [WIDTH-1:0] a_raw, mag, acc_hi, acc_lo;

    logic             a_neg, b_neg, start_zero, last_step;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign a_neg      = ~op[0] & a[WIDTH-1];
    assign b_neg      = ~op[0] & b[WIDTH-1];
    assign a_abs      = a_neg ? -a : a;
    assign b_abs      = b_neg ? -b : b;
    assign start_zero = op[1] & (b == '0);
    assign last_step  = (step == CW'(WIDTH - 1));
    assign busy       = (state != IDLE);

    // Multiply step: add the multiplicand when the current multiplier bit is set, then shift right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);

    // Restoring divide step: shift the next dividend bit into the partial remainder.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag});
    assign div_diff  = div_shift[WIDTH-1:0] - mag;

    logic               neg_res;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign neg_res  = sign_a ^ sign_b;
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -acc_lo : acc_lo;
    assign rem_fix  = sign_a ? -acc_hi : acc_hi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (ZERO_DIV_BYPASS && start_zero) ? FIX : CALC;
            CALC: if (last_step) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step     <= '0;
            op_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            mag      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div   <= op[1];
                        sign_a   <= a_neg;
                        sign_b   <= b_neg;
                        div_zero <= start_zero;
                        a_raw    <= a;
                        mag      <= op[1] ? b_abs : a_abs;
                        acc_hi   <= '0;
                        acc_lo   <= op[1] ? a_abs : b_abs;
                        step     <= '0;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                CALC: begin
                    step <= step + 1'b1;
                    if (op_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    // Divide by zero returns the raw dividend in HI and all ones in LO, signed or not.
                    if (div_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: arithmetic reference model plus per-cycle compare.
// Literal expected values from hand calculation pin both the DUT and the model.
module tb_muldiv_hilo_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;

    muldiv_hilo_unit #(.WIDTH(32), .ZERO_DIV_BYPASS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // reference: plain 64-bit arithmetic, result as {hi, lo}
    function automatic logic [63:0] ref_result(input logic [1:0] fop, input logic [31:0] fa,
                                                input logic [31:0] fb);
        longint      sa, sb, q, r;
        logic [63:0] u, qv, rv;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        if (!fop[1]) begin
            if (fop[0]) u = {32'b0, fa} * {32'b0, fb};
            else        u = sa * sb;
            return u;
        end
        if (fb == 32'd0) return {fa, 32'hFFFF_FFFF};
        if (fop[0]) return {fa % fb, fa / fb};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // model of architectural behaviour: latency counter and HI/LO contents
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    logic        cmp_en = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_pend = ref_result(op, a, b);
                m_left = (op[1] && b == 32'd0) ? 1 : 33;
            end else begin
                if (mthi) m_hi = a;
                if (mtlo) m_lo = a;
            end
        end
    end

    // scoreboard compare every cycle
    always @(negedge clk) begin
        if (cmp_en)
            check("cycle", {busy, done, hi, lo}, {(m_left > 0), m_done, m_hi, m_lo});
    end

    // driver tasks
    task automatic launch(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic with_mthi);
        @(posedge clk); #1;
        start = 1'b1; op = t_op; a = t_a; b = t_b; mthi = with_mthi;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
    endtask

    // counts cycles after the start edge until done; optional late mthi/start pokes
    task automatic wait_done(input int mthi_cyc, input int start_cyc, output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (n == mthi_cyc - 1) begin mthi = 1'b1; a = 32'hDEAD; end
            if (n == mthi_cyc)     mthi = 1'b0;
            if (n == start_cyc - 1) begin start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9; end
            if (n == start_cyc)    start = 1'b0;
        end
        mthi = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input logic [63:0] exp, input int exp_lat);
        int lat;
        check({name, "_model"}, {2'b0, ref_result(t_op, t_a, t_b)}, {2'b0, exp});
        launch(t_op, t_a, t_b, 1'b0);
        wait_done(0, 0, lat);
        check({name, "_latency"}, 66'(lat), 66'(exp_lat));
        check({name, "_hilo"}, {2'b0, hi, lo}, {2'b0, exp});
    endtask

    task automatic move_to(input logic set_hi, input logic set_lo, input logic [31:0] val);
        @(posedge clk); #1;
        mthi = set_hi; mtlo = set_lo; a = val;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    initial begin
        int lat;
        int dones;
        reset_n = 1'b0;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy, done, hi, lo}, 66'b0);
        reset_n = 1'b1;
        cmp_en = 1'b1;

        run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 34);
        run_op("mult_neg",    2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 34);
        run_op("mult_neg_b",  2'b00, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 34);
        run_op("mult_negneg", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006, 34);
        run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34);
        run_op("div_neg",     2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 34);
        run_op("div_negb",    2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 34);
        run_op("divu",        2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 34);
        run_op("divu_big",    2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 64'h0000_FFFF_0000_FFFF, 34);
        run_op("divu_zero",   2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 2);
        run_op("div_zero",    2'b10, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, 2);

        move_to(1'b1, 1'b0, 32'h1234);
        move_to(1'b0, 1'b1, 32'hABCD);
        check("mthi_mtlo", {2'b0, hi, lo}, {2'b0, 32'h1234, 32'hABCD});
        move_to(1'b1, 1'b1, 32'h5A5A);
        check("mt_both", {2'b0, hi, lo}, {2'b0, 32'h5A5A, 32'h5A5A});
        move_to(1'b1, 1'b1, 32'h1234);
        move_to(1'b0, 1'b1, 32'hABCD);

        // start with mthi in the same cycle, then poke mthi and start while busy
        launch(2'b01, 32'd2, 32'd3, 1'b1);
        check("start_beats_mthi", {2'b0, hi, lo}, {2'b0, 32'h1234, 32'hABCD});
        wait_done(10, 12, lat);
        check("busy_pokes_latency", 66'(lat), 66'd34);
        check("busy_pokes_hilo", {2'b0, hi, lo}, {2'b0, 32'd0, 32'd6});
        dones = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_requeued_start", 66'(dones), 66'd0);

        // asynchronous reset in the middle of a divide
        launch(2'b11, 32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("async_reset", {busy, done, hi, lo}, 66'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_reset", 66'(dones), 66'd0);

        run_op("divu_after_reset", 2'b11, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 34);

        repeat (3) @(posedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
